// File: rtl/ext_loader_if.sv
// ext_loader_if: host byte-stream bundle between the host link and ext_loader.
//   in_valid/in_data/in_ready    : command bytes, host -> loader
//   out_valid/out_data/out_ready : readback bytes, loader -> host
// A byte transfers on a rising edge where valid && ready.
interface ext_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  // Host side drives commands and accepts readback.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ext_loader.sv
// ext_loader: decodes a host byte-stream command protocol and drives the
// external instruction/data memory ports plus CPU run control.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : command in / readback out byte streams
//   o_addr_ext/o_wen_ext/o_ren_ext/o_wdata_ext       : IMEM port (ren unused, tied 0)
//   o_addr_ext_2/o_wen_ext_2/o_ren_ext_2/o_wdata_ext_2 : DMEM port
//   i_rdata_ext_2       : DMEM read word, valid RD_LAT cycles after ren pulse
//   o_cpu_enable        : CPU enable
//   o_busy, o_err       : not-idle flag, one-cycle unknown-opcode pulse
module ext_loader #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  ext_loader_if.slave        bus,
  output logic [63:0]        o_addr_ext,
  output logic               o_wen_ext,
  output logic               o_ren_ext,
  output logic [31:0]        o_wdata_ext,
  output logic [63:0]        o_addr_ext_2,
  output logic               o_wen_ext_2,
  output logic               o_ren_ext_2,
  output logic [63:0]        o_wdata_ext_2,
  input  logic [63:0]        i_rdata_ext_2,
  output logic               o_cpu_enable,
  output logic               o_busy,
  output logic               o_err
);

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned IDX_W  = 16;
  localparam int unsigned LAT_W  = 2;

  localparam logic [7:0] OP_IMEM_WR = 8'h01;
  localparam logic [7:0] OP_DMEM_WR = 8'h02;
  localparam logic [7:0] OP_DMEM_RD = 8'h03;
  localparam logic [7:0] OP_START   = 8'h04;
  localparam logic [7:0] OP_STOP    = 8'h05;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR0, S_ADDR1, S_CNT0, S_CNT1,
    S_WR_COLLECT, S_WR_ISSUE, S_RD_ISSUE, S_RD_WAIT, S_RD_SEND
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_op, w_op_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [IDX_W-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]         r_bsel, w_bsel_nxt;
  logic [63:0]        r_wbuf, w_wbuf_nxt;
  logic [63:0]        r_rbuf, w_rbuf_nxt;
  logic [LAT_W-1:0]   r_lat, w_lat_nxt;

  logic               r_in_ready, w_in_ready_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [7:0]         r_out_data, w_out_data_nxt;
  logic [ADDR_W-1:0]  r_addr_ext, w_addr_ext_nxt;
  logic               r_wen_ext, w_wen_ext_nxt;
  logic [31:0]        r_wdata_ext, w_wdata_ext_nxt;
  logic [ADDR_W-1:0]  r_addr_ext_2, w_addr_ext_2_nxt;
  logic               r_wen_ext_2, w_wen_ext_2_nxt;
  logic               r_ren_ext_2, w_ren_ext_2_nxt;
  logic [63:0]        r_wdata_ext_2, w_wdata_ext_2_nxt;
  logic               r_cpu_enable, w_cpu_enable_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_err, w_err_nxt;

  logic w_in_fire, w_out_fire, w_last_word, w_last_byte;

  assign w_in_fire   = bus.in_valid && r_in_ready;
  assign w_out_fire  = r_out_valid && bus.out_ready;
  assign w_last_word = (r_cnt == IDX_W'(1));
  assign w_last_byte = (r_op == OP_IMEM_WR) ? (r_bsel == 3'd3) : (r_bsel == 3'd7);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_bsel_nxt       = r_bsel;
    w_wbuf_nxt       = r_wbuf;
    w_rbuf_nxt       = r_rbuf;
    w_lat_nxt        = r_lat;
    w_out_valid_nxt  = r_out_valid;
    w_out_data_nxt   = r_out_data;
    w_cpu_enable_nxt = r_cpu_enable;
    w_err_nxt        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_in_fire) begin
          case (bus.in_data)
            OP_IMEM_WR, OP_DMEM_WR, OP_DMEM_RD: begin
              // Any memory command stops the CPU first.
              w_op_nxt         = bus.in_data;
              w_cpu_enable_nxt = 1'b0;
              w_state_nxt      = S_ADDR0;
            end
            OP_START: w_cpu_enable_nxt = 1'b1;
            OP_STOP:  w_cpu_enable_nxt = 1'b0;
            default:  w_err_nxt        = 1'b1;
          endcase
        end
      end
      S_ADDR0: if (w_in_fire) begin
        w_idx_nxt[7:0] = bus.in_data;
        w_state_nxt    = S_ADDR1;
      end
      S_ADDR1: if (w_in_fire) begin
        w_idx_nxt[15:8] = bus.in_data;
        w_state_nxt     = S_CNT0;
      end
      S_CNT0: if (w_in_fire) begin
        w_cnt_nxt[7:0] = bus.in_data;
        w_state_nxt    = S_CNT1;
      end
      S_CNT1: if (w_in_fire) begin
        w_cnt_nxt[15:8] = bus.in_data;
        w_bsel_nxt      = 3'd0;
        w_wbuf_nxt      = '0;
        if ({bus.in_data, r_cnt[7:0]} == 16'd0) w_state_nxt = S_IDLE;
        else if (r_op == OP_DMEM_RD)             w_state_nxt = S_RD_ISSUE;
        else                                     w_state_nxt = S_WR_COLLECT;
      end
      S_WR_COLLECT: if (w_in_fire) begin
        // Little-endian assembly: byte n lands in bits [8n+7:8n].
        w_wbuf_nxt[{r_bsel, 3'b000} +: 8] = bus.in_data;
        w_bsel_nxt = r_bsel + 3'd1;
        if (w_last_byte) w_state_nxt = S_WR_ISSUE;
      end
      S_WR_ISSUE: begin
        w_idx_nxt   = r_idx + IDX_W'(1);
        w_cnt_nxt   = r_cnt - IDX_W'(1);
        w_bsel_nxt  = 3'd0;
        w_wbuf_nxt  = '0;
        w_state_nxt = w_last_word ? S_IDLE : S_WR_COLLECT;
      end
      S_RD_ISSUE: begin
        w_lat_nxt   = '0;
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Capture on the last wait cycle, i.e. RD_LAT cycles after the pulse.
        if (r_lat == LAT_W'(RD_LAT - 1)) begin
          w_rbuf_nxt      = i_rdata_ext_2;
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = i_rdata_ext_2[7:0];
          w_bsel_nxt      = 3'd0;
          w_state_nxt     = S_RD_SEND;
        end else begin
          w_lat_nxt = r_lat + LAT_W'(1);
        end
      end
      S_RD_SEND: if (w_out_fire) begin
        if (r_bsel == 3'd7) begin
          w_out_valid_nxt = 1'b0;
          w_out_data_nxt  = 8'h00;
          w_idx_nxt       = r_idx + IDX_W'(1);
          w_cnt_nxt       = r_cnt - IDX_W'(1);
          w_state_nxt     = w_last_word ? S_IDLE : S_RD_ISSUE;
        end else begin
          w_bsel_nxt     = r_bsel + 3'd1;
          w_rbuf_nxt     = {8'h00, r_rbuf[63:8]};
          w_out_data_nxt = r_rbuf[15:8];
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Strobes and status follow the state being entered so they are valid
    // exactly during that state's cycle.
    w_in_ready_nxt = (w_state_nxt == S_IDLE)  || (w_state_nxt == S_ADDR0) ||
                     (w_state_nxt == S_ADDR1) || (w_state_nxt == S_CNT0)  ||
                     (w_state_nxt == S_CNT1)  || (w_state_nxt == S_WR_COLLECT);
    w_busy_nxt        = (w_state_nxt != S_IDLE);
    w_wen_ext_nxt     = (w_state_nxt == S_WR_ISSUE) && (r_op == OP_IMEM_WR);
    w_wen_ext_2_nxt   = (w_state_nxt == S_WR_ISSUE) && (r_op == OP_DMEM_WR);
    w_ren_ext_2_nxt   = (w_state_nxt == S_RD_ISSUE);
    w_addr_ext_nxt    = w_wen_ext_nxt ? ADDR_W'({w_idx_nxt, 2'b00}) : '0;
    w_wdata_ext_nxt   = w_wen_ext_nxt ? w_wbuf_nxt[31:0] : '0;
    w_addr_ext_2_nxt  = (w_wen_ext_2_nxt || w_ren_ext_2_nxt) ?
                        ADDR_W'({w_idx_nxt, 3'b000}) : '0;
    w_wdata_ext_2_nxt = w_wen_ext_2_nxt ? w_wbuf_nxt : '0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_bsel        <= '0;
      r_wbuf        <= '0;
      r_rbuf        <= '0;
      r_lat         <= '0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_addr_ext    <= '0;
      r_wen_ext     <= 1'b0;
      r_wdata_ext   <= '0;
      r_addr_ext_2  <= '0;
      r_wen_ext_2   <= 1'b0;
      r_ren_ext_2   <= 1'b0;
      r_wdata_ext_2 <= '0;
      r_cpu_enable  <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_op          <= w_op_nxt;
      r_idx         <= w_idx_nxt;
      r_cnt         <= w_cnt_nxt;
      r_bsel        <= w_bsel_nxt;
      r_wbuf        <= w_wbuf_nxt;
      r_rbuf        <= w_rbuf_nxt;
      r_lat         <= w_lat_nxt;
      r_in_ready    <= w_in_ready_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_data    <= w_out_data_nxt;
      r_addr_ext    <= w_addr_ext_nxt;
      r_wen_ext     <= w_wen_ext_nxt;
      r_wdata_ext   <= w_wdata_ext_nxt;
      r_addr_ext_2  <= w_addr_ext_2_nxt;
      r_wen_ext_2   <= w_wen_ext_2_nxt;
      r_ren_ext_2   <= w_ren_ext_2_nxt;
      r_wdata_ext_2 <= w_wdata_ext_2_nxt;
      r_cpu_enable  <= w_cpu_enable_nxt;
      r_busy        <= w_busy_nxt;
      r_err         <= w_err_nxt;
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign o_addr_ext     = r_addr_ext;
  assign o_wen_ext      = r_wen_ext;
  assign o_ren_ext      = 1'b0;
  assign o_wdata_ext    = r_wdata_ext;
  assign o_addr_ext_2   = r_addr_ext_2;
  assign o_wen_ext_2    = r_wen_ext_2;
  assign o_ren_ext_2    = r_ren_ext_2;
  assign o_wdata_ext_2  = r_wdata_ext_2;
  assign o_cpu_enable   = r_cpu_enable;
  assign o_busy         = r_busy;
  assign o_err          = r_err;

endmodule

// File: tb/tb_ext_loader.sv
// tb_ext_loader: scoreboard bench for ext_loader. Expected memory-port events
// and readback bytes are queued as stimulus is sent; a negedge monitor records
// what the DUT actually does, and each scenario task compares the two.
module tb_ext_loader;

  logic        clk;
  logic        rst;
  logic [63:0] o_addr_ext, o_addr_ext_2, o_wdata_ext_2, rdata_ext_2;
  logic [31:0] o_wdata_ext;
  logic        o_wen_ext, o_ren_ext, o_wen_ext_2, o_ren_ext_2;
  logic        o_cpu_enable, o_busy, o_err;

  ext_loader_if bus_if();

  ext_loader #(.RD_LAT(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_if),
    .o_addr_ext    (o_addr_ext),
    .o_wen_ext     (o_wen_ext),
    .o_ren_ext     (o_ren_ext),
    .o_wdata_ext   (o_wdata_ext),
    .o_addr_ext_2  (o_addr_ext_2),
    .o_wen_ext_2   (o_wen_ext_2),
    .o_ren_ext_2   (o_ren_ext_2),
    .o_wdata_ext_2 (o_wdata_ext_2),
    .i_rdata_ext_2 (rdata_ext_2),
    .o_cpu_enable  (o_cpu_enable),
    .o_busy        (o_busy),
    .o_err         (o_err)
  );

  // kind: 0 = IMEM write, 1 = DMEM write, 2 = DMEM read
  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] addr;
    logic [63:0] data;
  } ev_t;

  ev_t        exp_ev[$];
  ev_t        obs_ev[$];
  logic [7:0] exp_b[$];
  logic [7:0] obs_b[$];
  int         checks;
  int         failures;
  bit         mon_en;
  bit         stall_en;
  bit         prev_stall;
  logic [7:0] prev_data;
  logic [63:0] dmem [logic [63:0]];
  logic [240:0] all_out;

  assign all_out = {o_addr_ext, o_wen_ext, o_ren_ext, o_wdata_ext, o_addr_ext_2,
                    o_wen_ext_2, o_ren_ext_2, o_wdata_ext_2, o_cpu_enable, o_busy,
                    o_err, bus_if.in_ready, bus_if.out_valid, bus_if.out_data};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data-memory model: one-cycle read latency, garbage on all other cycles.
  always @(posedge clk) begin
    if (o_wen_ext_2 === 1'b1) dmem[o_addr_ext_2] = o_wdata_ext_2;
    if (o_ren_ext_2 === 1'b1)
      rdata_ext_2 <= dmem.exists(o_addr_ext_2) ? dmem[o_addr_ext_2] : 64'h0;
    else
      rdata_ext_2 <= {$urandom, $urandom};
  end

  // Readback consumer, optionally stalling at random.
  always @(posedge clk) begin
    #1;
    bus_if.out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: record port events, check strobe exclusivity and output hold.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (o_wen_ext)   obs_ev.push_back(ev_t'{2'd0, o_addr_ext, 64'(o_wdata_ext)});
      if (o_wen_ext_2) obs_ev.push_back(ev_t'{2'd1, o_addr_ext_2, o_wdata_ext_2});
      if (o_ren_ext_2) obs_ev.push_back(ev_t'{2'd2, o_addr_ext_2, 64'h0});
      checks++;
      if (o_wen_ext || o_wen_ext_2 || o_ren_ext_2 || o_ren_ext) begin
        if ($countones({o_wen_ext, o_ren_ext, o_wen_ext_2, o_ren_ext_2}) != 1 || o_ren_ext) begin
          failures++;
          $display("FAIL strobe_onehot got wen=%b ren=%b wen2=%b ren2=%b want one of wen/wen2/ren2",
                   o_wen_ext, o_ren_ext, o_wen_ext_2, o_ren_ext_2);
        end
      end else if (o_wdata_ext !== 32'h0 || o_wdata_ext_2 !== 64'h0) begin
        failures++;
        $display("FAIL idle_wdata got wdata=%h wdata2=%h want 0", o_wdata_ext, o_wdata_ext_2);
      end
      if (prev_stall) begin
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== prev_data) begin
          failures++;
          $display("FAIL out_hold got valid=%b data=%h want valid=1 data=%h",
                   bus_if.out_valid, bus_if.out_data, prev_data);
        end
      end
      if (bus_if.out_valid && bus_if.out_ready) obs_b.push_back(bus_if.out_data);
      prev_stall = bus_if.out_valid && !bus_if.out_ready;
      prev_data  = bus_if.out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = b;
    while (bus_if.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout byte=%h got in_ready=%b want 1", b, bus_if.in_ready);
    end
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    @(negedge clk);
    while ((o_busy !== 1'b0 || bus_if.out_valid !== 1'b0) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout got busy=%b out_valid=%b want 0", o_busy, bus_if.out_valid);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %h want 0", all_out);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus_if.in_ready !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got in_ready=%b busy=%b want 1/0", bus_if.in_ready, o_busy);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_imem_load();
    logic [7:0] q[$];
    ev_t e, o;
    q = '{8'h01, 8'h02, 8'h00, 8'h02, 8'h00,
          8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    exp_ev.push_back(ev_t'{2'd0, 64'h8, 64'h0000_0013});
    exp_ev.push_back(ev_t'{2'd0, 64'hC, 64'h0010_0093});
    foreach (q[i]) send_byte(q[i]);
    checks++;
    if (o_wen_ext !== 1'b1 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL imem_last_pulse got wen=%b busy=%b want 1/1", o_wen_ext, o_busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_wen_ext !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL imem_busy_fall got wen=%b busy=%b want 0/0", o_wen_ext, o_busy);
    end
    wait_idle(100);
    checks++;
    if (obs_ev.size() != exp_ev.size()) begin
      failures++;
      $display("FAIL imem_count got %0d want %0d", obs_ev.size(), exp_ev.size());
    end
    while (exp_ev.size() > 0 && obs_ev.size() > 0) begin
      e = exp_ev.pop_front();
      o = obs_ev.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL imem_write got k=%0d a=%h d=%h want k=%0d a=%h d=%h",
                 o.kind, o.addr, o.data, e.kind, e.addr, e.data);
      end
    end
    exp_ev.delete();
    obs_ev.delete();
  endtask

  task automatic test_dmem_roundtrip();
    logic [7:0] q[$];
    ev_t e, o;
    logic [7:0] eb, ob;
    stall_en = 1'b1;
    q = '{8'h02, 8'h03, 8'h00, 8'h01, 8'h00,
          8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11,
          8'h03, 8'h03, 8'h00, 8'h01, 8'h00};
    exp_ev.push_back(ev_t'{2'd1, 64'h18, 64'h1122_3344_5566_7788});
    exp_ev.push_back(ev_t'{2'd2, 64'h18, 64'h0});
    exp_b = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    foreach (q[i]) send_byte(q[i]);
    wait_idle(500);
    stall_en = 1'b0;
    checks++;
    if (obs_ev.size() != exp_ev.size()) begin
      failures++;
      $display("FAIL dmem_count got %0d want %0d", obs_ev.size(), exp_ev.size());
    end
    while (exp_ev.size() > 0 && obs_ev.size() > 0) begin
      e = exp_ev.pop_front();
      o = obs_ev.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL dmem_access got k=%0d a=%h d=%h want k=%0d a=%h d=%h",
                 o.kind, o.addr, o.data, e.kind, e.addr, e.data);
      end
    end
    checks++;
    if (obs_b.size() != exp_b.size()) begin
      failures++;
      $display("FAIL rd_byte_count got %0d want %0d", obs_b.size(), exp_b.size());
    end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      eb = exp_b.pop_front();
      ob = obs_b.pop_front();
      checks++;
      if (ob !== eb) begin
        failures++;
        $display("FAIL rd_byte got %h want %h", ob, eb);
      end
    end
    exp_ev.delete(); obs_ev.delete(); exp_b.delete(); obs_b.delete();
  endtask

  task automatic test_run_control();
    logic [7:0] q[$];
    send_byte(8'h04);
    checks++;
    if (o_cpu_enable !== 1'b1) begin
      failures++;
      $display("FAIL start got cpu_enable=%b want 1", o_cpu_enable);
    end
    send_byte(8'h02);
    checks++;
    if (o_cpu_enable !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL implicit_stop got cpu_enable=%b busy=%b want 0/1", o_cpu_enable, o_busy);
    end
    q = '{8'h00, 8'h00, 8'h00, 8'h00};
    foreach (q[i]) send_byte(q[i]);
    wait_idle(50);
    send_byte(8'h05);
    checks++;
    if (o_cpu_enable !== 1'b0 || o_err !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_when_stopped got en=%b err=%b busy=%b want 0/0/0",
               o_cpu_enable, o_err, o_busy);
    end
    send_byte(8'h04);
    send_byte(8'h05);
    checks++;
    if (o_cpu_enable !== 1'b0) begin
      failures++;
      $display("FAIL stop got cpu_enable=%b want 0", o_cpu_enable);
    end
    checks++;
    if (obs_ev.size() != 0) begin
      failures++;
      $display("FAIL run_ctrl_no_access got %0d events want 0", obs_ev.size());
    end
    obs_ev.delete();
  endtask

  task automatic test_errors();
    logic [7:0] q[$];
    ev_t e, o;
    send_byte(8'h7F);
    checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL err_pulse got err=%b busy=%b in_ready=%b want 1/0/1",
               o_err, o_busy, bus_if.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_err !== 1'b0) begin
      failures++;
      $display("FAIL err_single got err=%b want 0", o_err);
    end
    // Index wrap 0xFFFF -> 0x0000 within one command.
    q = '{8'h01, 8'hFF, 8'hFF, 8'h02, 8'h00,
          8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    exp_ev.push_back(ev_t'{2'd0, 64'h3FFFC, 64'h4433_2211});
    exp_ev.push_back(ev_t'{2'd0, 64'h0, 64'h8877_6655});
    foreach (q[i]) send_byte(q[i]);
    wait_idle(100);
    // CNT = 0: no memory access.
    q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    foreach (q[i]) send_byte(q[i]);
    wait_idle(50);
    checks++;
    if (obs_ev.size() != exp_ev.size()) begin
      failures++;
      $display("FAIL wrap_count got %0d want %0d", obs_ev.size(), exp_ev.size());
    end
    while (exp_ev.size() > 0 && obs_ev.size() > 0) begin
      e = exp_ev.pop_front();
      o = obs_ev.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wrap_write got k=%0d a=%h d=%h want k=%0d a=%h d=%h",
                 o.kind, o.addr, o.data, e.kind, e.addr, e.data);
      end
    end
    exp_ev.delete();
    obs_ev.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    foreach (q[i]) send_byte(q[i]);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got %h want 0", all_out);
    end
    rst = 1'b0;
    send_byte(8'h04);
    checks++;
    if (o_cpu_enable !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_start got en=%b busy=%b want 1/0", o_cpu_enable, o_busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (obs_ev.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_no_write got %0d events want 0", obs_ev.size());
    end
    obs_ev.delete();
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    mon_en          = 1'b0;
    stall_en        = 1'b0;
    prev_stall      = 1'b0;
    prev_data       = 8'h00;
    rst             = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'h00;
    bus_if.out_ready = 1'b1;
    rdata_ext_2     = 64'h0;
    test_reset();
    test_imem_load();
    test_dmem_roundtrip();
    test_run_control();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ext_loader.md
EXT_LOADER -- requirements
Module: ext_loader

Interface
REQ-001 RD_LAT, 1, cycles from the ren_ext_2 pulse until rdata_ext_2 is valid (1..4).
REQ-002 clk  input  1  single clock; all logic on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid / in_data / in_ready  input / input[8] / output  host command byte stream; a byte transfers when valid && ready.
REQ-005 out_valid / out_data / out_ready  output / output[8] / input  readback byte stream, same handshake.
REQ-006 addr_ext, wen_ext, ren_ext, wdata_ext  output  64/1/1/32  instruction-memory external port.
REQ-007 addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2  output  64/1/1/64  data-memory external port.
REQ-008 rdata_ext_2  input  64  data-memory read word.
REQ-009 cpu_enable  output  1  drives the CPU enable.
REQ-010 busy, err  output  1/1  busy is high in any state other than IDLE; err is a one-cycle error pulse.

Function
REQ-011 Command frame: opcode byte, then ADDR (16-bit word index, LSB first), then CNT (16-bit word count, LSB first), then payload.
- Opcode 0x01: IMEM write.
- Opcode 0x02: DMEM write.
- Opcode 0x03: DMEM read.
- Opcode 0x04: start.
- Opcode 0x05: stop.
- Opcodes 0x04 and 0x05 have no ADDR, CNT or payload.
REQ-012 FSM states: IDLE, ADDR0, ADDR1, CNT0, CNT1, WR_COLLECT, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_SEND.
REQ-013 in_ready is high only in IDLE, ADDR0/1, CNT0/1 and WR_COLLECT.
REQ-014 Start/stop: on acceptance of 0x04, cpu_enable is set the next cycle; on 0x05 it is cleared the next cycle. The FSM stays in IDLE.
REQ-015 Unknown opcode: err pulses for one cycle the cycle after acceptance; the byte is dropped; the FSM stays in IDLE.
REQ-016 Implicit stop: accepting opcode 0x01, 0x02 or 0x03 clears cpu_enable the next cycle; it stays clear until the next 0x04.
REQ-017 CNT=0: the FSM returns to IDLE after CNT1 with no memory access.
REQ-018 Byte address = word index × 4 for IMEM and × 8 for DMEM. The address is zero-extended to 64 bits.
REQ-019 The word index increments by 1 per word and wraps 0xFFFF to 0x0000 within a command.
REQ-020 Write payload is little-endian: 4 bytes per IMEM word, 8 bytes per DMEM word.
REQ-021 Write timing: the cycle after the last byte of a word is accepted (WR_ISSUE), the FSM drives exactly one cycle of:
- wen_ext=1 with addr_ext and wdata_ext for IMEM, or
- wen_ext_2=1 with addr_ext_2 and wdata_ext_2 for DMEM.
It then returns to WR_COLLECT, or to IDLE after word CNT.
REQ-022 Read timing:
- RD_ISSUE: one cycle with ren_ext_2=1 and addr_ext_2 valid.
- RD_WAIT: RD_LAT cycles; rdata_ext_2 is captured on the last cycle.
- RD_SEND: emits the 8 bytes LSB first.
After word CNT the FSM returns to IDLE; otherwise it returns to RD_ISSUE.
REQ-023 While out_valid=1 and out_ready=0, out_data holds stable. out_valid never drops before the byte transfers.
REQ-024 At most one of wen_ext, ren_ext, wen_ext_2, ren_ext_2 is high in any cycle. ren_ext is held at 0.
REQ-025 Outside their pulse cycles, wen/ren are 0 and wdata outputs hold 0.
REQ-026 CNT is a 16-bit unsigned count, so one command moves at most 65535 words.

Reset
REQ-027 While rst=1 at a clock edge, the next state is:
- FSM in IDLE;
- every output 0, including cpu_enable, in_ready, out_valid, busy and err;
- all address, count and data registers cleared.
REQ-028 Reset mid-command abandons the command. There is no partial write after reset, and the next byte after reset is decoded as an opcode.
REQ-029 in_ready rises the first cycle after rst deasserts.

Verification
REQ-030 IMEM load: frame 01 02 00 02 00 then bytes 13 00 00 00 93 00 10 00 -> two one-cycle wen_ext pulses:
- addr_ext=0x8 with wdata_ext=0x00000013;
- addr_ext=0xC with wdata_ext=0x00100093;
- busy falls after the second pulse.
REQ-031 DMEM round trip with RD_LAT=1 and random out_ready stalls: write word 0x1122334455667788 at index 3, then 03 03 00 01 00 -> ren_ext_2 with addr_ext_2=0x18, then out bytes 88 77 66 55 44 33 22 11 in order, each held stable through stalls.
REQ-032 Run control: 04 -> cpu_enable=1 the next cycle. A following 02 frame -> cpu_enable=0 the cycle after the opcode. 05 while already stopped -> no change.
REQ-033 Error and corner cases:
- opcode 0x7F -> single err pulse, no port activity;
- 01 FF FF 02 00 with 8 data bytes -> writes at 0x3FFFC then 0x0 (index wrap);
- 01 00 00 00 00 -> no writes.
REQ-034 Reset mid-operation: assert rst after 3 of 4 data bytes of an IMEM word -> no wen_ext pulse and all outputs 0. The next 04 after reset -> cpu_enable=1.
